// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder: active-high glyph
// patterns (bit0=a .. bit6=g), digit codes, anode classes and a helper
// that maps a digit code to its numeric weight.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;

    // Non-numeric digit codes
    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [3:0] DASH  = 4'hE;
    localparam logic [3:0] INVAL = 4'hD;

    typedef enum logic [1:0] {
        AN_GAP   = 2'd0,
        AN_DIGIT = 2'd1,
        AN_MULTI = 2'd2
    } an_class_e;

    // Numeric value of a digit code; BLANK/DASH/INVAL contribute 0
    function automatic logic [13:0] code_value(input logic [3:0] code);
        return (code <= 4'd9) ? {10'd0, code} : '0;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Display-side bus (active-low segments and anodes) and the recovered
// frame outputs of the scan decoder.
interface seven_seg_scan_decoder_if;
    import seven_seg_pkg::*;

    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [NUM_DIGITS*4-1:0] digits;
    logic [13:0]             value;
    logic                    frame_valid;
    logic                    frame_dash;
    logic                    glyph_err;
    logic                    anode_err;

    // Display path / stimulus side
    modport master (
        output seg_in, an_in,
        input  digits, value, frame_valid, frame_dash, glyph_err, anode_err
    );

    // Decoder side
    modport slave (
        input  seg_in, an_in,
        output digits, value, frame_valid, frame_dash, glyph_err, anode_err
    );

endinterface

// File: rtl/seven_seg_scan_decoder_glyph_decode.sv
// Combinational glyph decoder: active-high segment pattern to digit code.
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code
);

    // Exact-match lookup; anything not in the table is undecodable
    always_comb begin
        o_code = INVAL;
        case (i_seg)
            GLYPH_0:     o_code = 4'd0;
            GLYPH_1:     o_code = 4'd1;
            GLYPH_2:     o_code = 4'd2;
            GLYPH_3:     o_code = 4'd3;
            GLYPH_4:     o_code = 4'd4;
            GLYPH_5:     o_code = 4'd5;
            GLYPH_6:     o_code = 4'd6;
            GLYPH_7:     o_code = 4'd7;
            GLYPH_8:     o_code = 4'd8;
            GLYPH_9:     o_code = 4'd9;
            GLYPH_BLANK: o_code = BLANK;
            GLYPH_DASH:  o_code = DASH;
            default:     o_code = INVAL;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Scan decoder: registers the multiplexed display lines, waits for each
// digit to settle, decodes it, and emits complete 4-digit frames with the
// binary value and glyph/anode error flags.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    seven_seg_scan_decoder_if.slave bus
);

    // Capture happens on the edge where the counter steps to SETTLE_CYCLES-1
    localparam logic [3:0] CAP_CNT = 4'(SETTLE_CYCLES - 2);

    logic [6:0]                  r_seg;
    logic [NUM_DIGITS-1:0]       r_an;
    logic [3:0]                  r_cnt;
    logic [NUM_DIGITS-1:0][3:0]  r_work;
    logic [NUM_DIGITS-1:0]       r_wvalid;
    logic [NUM_DIGITS*4-1:0]     r_digits;
    logic [13:0]                 r_value;
    logic                        r_frame_valid;
    logic                        r_frame_dash;
    logic                        r_glyph_err;
    logic                        r_anode_err;

    logic [NUM_DIGITS-1:0]       w_an_low;
    an_class_e                   w_class;
    logic [1:0]                  w_idx;
    logic                        w_chg;
    logic                        w_capture;
    logic                        w_emit;
    logic [3:0]                  w_code;
    logic [13:0]                 w_value;
    logic                        w_has_dash;
    logic                        w_has_inval;

    // Input stage: one register on the pins, reset to a blank gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '1;
            r_an  <= '1;
        end else begin
            r_seg <= bus.seg_in;
            r_an  <= bus.an_in;
        end
    end

    // Anode classification of the registered lines
    always_comb begin
        w_an_low = ~r_an;
        w_class  = AN_GAP;
        w_idx    = '0;
        if ($onehot(w_an_low)) begin
            w_class = AN_DIGIT;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_an_low[i]) w_idx = i[1:0];
            end
        end else if (w_an_low != '0) begin
            w_class = AN_MULTI;
        end
    end

    seven_seg_glyph_decode u_decode (
        .i_seg  (~r_seg),
        .o_code (w_code)
    );

    // Change of the registered pair is detected one edge early by comparing
    // the pins against the register, so the counter restarts on the same
    // edge the new pattern is registered.
    assign w_chg     = {bus.an_in, bus.seg_in} != {r_an, r_seg};
    assign w_capture = (w_class == AN_DIGIT) && !w_chg && (r_cnt == CAP_CNT);
    assign w_emit    = &r_wvalid;

    // Settle counter: restart on change or gap, otherwise saturating count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_chg || (w_class != AN_DIGIT)) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Working digit registers; a capture on the emit edge lands after the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_wvalid <= '0;
        end else begin
            if (w_emit) r_wvalid <= '0;
            if (w_capture) begin
                r_work[w_idx]   <= w_code;
                r_wvalid[w_idx] <= 1'b1;
            end
        end
    end

    // Frame summary of the working codes
    always_comb begin
        w_has_dash  = 1'b0;
        w_has_inval = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_work[i] == DASH)  w_has_dash  = 1'b1;
            if (r_work[i] == INVAL) w_has_inval = 1'b1;
        end
        w_value = code_value(r_work[3]) * 14'd1000
                + code_value(r_work[2]) * 14'd100
                + code_value(r_work[1]) * 14'd10
                + code_value(r_work[0]);
    end

    // Frame register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits      <= '0;
            r_value       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_dash  <= 1'b0;
            r_glyph_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_emit;
            if (w_emit) begin
                r_digits     <= r_work;
                r_value      <= w_value;
                r_frame_dash <= w_has_dash;
                r_glyph_err  <= w_has_inval;
            end
        end
    end

    // Sticky anode error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode_err <= 1'b0;
        end else if (w_class == AN_MULTI) begin
            r_anode_err <= 1'b1;
        end
    end

    assign bus.digits      = r_digits;
    assign bus.value       = r_value;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_dash  = r_frame_dash;
    assign bus.glyph_err   = r_glyph_err;
    assign bus.anode_err   = r_anode_err;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with SETTLE_CYCLES=4.
module tb_seven_seg_scan_decoder;
    import seven_seg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned fv_count = 0;
    int unsigned n0;

    seven_seg_scan_decoder_if bus ();

    seven_seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count cycles with frame_valid high
    always @(negedge clk) begin
        if (bus.frame_valid) fv_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int unsigned n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One digit for 16 cycles followed by a 2-cycle gap
    task automatic show(input int unsigned i, input logic [6:0] pat);
        drive(~(4'(4'b0001 << i)), ~pat, 16);
        drive(4'hF, 7'h7F, 2);
    endtask

    task automatic scan(input logic [6:0] g3, input logic [6:0] g2,
                        input logic [6:0] g1, input logic [6:0] g0);
        show(0, g0);
        show(1, g1);
        show(2, g2);
        show(3, g3);
    endtask

    initial begin
        bus.an_in  = 4'hF;
        bus.seg_in = 7'h7F;
        #12;
        check("rst_digits", 32'(bus.digits), 32'h0000);
        check("rst_value", 32'(bus.value), 0);
        check("rst_flags", {28'd0, bus.frame_valid, bus.frame_dash, bus.glyph_err, bus.anode_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "1234" twice: one pulse per scan
        n0 = fv_count;
        scan(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        check("s1234_pulses", fv_count - n0, 1);
        check("s1234_digits", 32'(bus.digits), 32'h1234);
        check("s1234_value", 32'(bus.value), 1234);
        check("s1234_flags", {29'd0, bus.frame_dash, bus.glyph_err, bus.anode_err}, 0);
        n0 = fv_count;
        scan(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        check("s1234b_pulses", fv_count - n0, 1);
        check("s1234b_value", 32'(bus.value), 1234);

        // Blank thousands "_987"
        n0 = fv_count;
        scan(GLYPH_BLANK, GLYPH_9, GLYPH_8, GLYPH_7);
        check("blank_pulses", fv_count - n0, 1);
        check("blank_digits", 32'(bus.digits), 32'hF987);
        check("blank_value", 32'(bus.value), 987);
        check("blank_gerr", 32'(bus.glyph_err), 0);

        // All dashes
        scan(GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH);
        check("dash_digits", 32'(bus.digits), 32'hEEEE);
        check("dash_value", 32'(bus.value), 0);
        check("dash_flag", 32'(bus.frame_dash), 1);
        check("dash_gerr", 32'(bus.glyph_err), 0);

        // Undecodable glyph on digit 2 (bus pattern 7'b1010101)
        n0 = fv_count;
        scan(GLYPH_1, 7'b0101010, GLYPH_3, GLYPH_4);
        check("inv_pulses", fv_count - n0, 1);
        check("inv_digits", 32'(bus.digits), 32'h1D34);
        check("inv_value", 32'(bus.value), 1034);
        check("inv_gerr", 32'(bus.glyph_err), 1);
        check("inv_dash", 32'(bus.frame_dash), 0);
        scan(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        check("clean_gerr", 32'(bus.glyph_err), 0);
        check("clean_digits", 32'(bus.digits), 32'h1234);

        // 2-cycle glitch on digit 0, then a two-anode pattern
        n0 = fv_count;
        drive(4'b1110, ~GLYPH_3, 8);
        drive(4'b1110, ~GLYPH_8, 2);
        drive(4'hF, 7'h7F, 2);
        check("pre_anerr", 32'(bus.anode_err), 0);
        drive(4'b1100, ~GLYPH_9, 8);
        drive(4'hF, 7'h7F, 2);
        check("anerr_set", 32'(bus.anode_err), 1);
        show(1, GLYPH_6);
        show(2, GLYPH_5);
        show(3, GLYPH_4);
        check("glitch_pulses", fv_count - n0, 1);
        check("glitch_digits", 32'(bus.digits), 32'h4563);
        check("glitch_value", 32'(bus.value), 4563);
        scan(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        check("anerr_sticky", 32'(bus.anode_err), 1);

        // Reset after three captured digits
        show(0, GLYPH_8);
        show(1, GLYPH_7);
        show(2, GLYPH_6);
        rst_n = 1'b0;
        #2;
        check("mid_rst_digits", 32'(bus.digits), 0);
        check("mid_rst_value", 32'(bus.value), 0);
        check("mid_rst_flags", {28'd0, bus.frame_valid, bus.frame_dash, bus.glyph_err, bus.anode_err}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = fv_count;
        show(3, GLYPH_5);
        check("post_rst_nopulse", fv_count - n0, 0);
        check("post_rst_digits", 32'(bus.digits), 0);
        scan(GLYPH_5, GLYPH_6, GLYPH_7, GLYPH_8);
        check("post_rst_pulses", fv_count - n0, 1);
        check("post_rst_frame", 32'(bus.digits), 32'h5678);
        check("post_rst_value", 32'(bus.value), 5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
